// File: rtl/irf_bypass_ctrl_pkg.sv
// Shared types and constants for the integer register file bypass control.
package irf_bypass_ctrl_pkg;

  // Register address width and the hard-wired zero register.
  localparam int NREG_BITS = 5;
  localparam logic [NREG_BITS-1:0] ZERO_REG = 5'd31;

  // Operand mux select codes; 5-7 are never produced.
  localparam logic [2:0] SEL_RF   = 3'd0;  // register file read port
  localparam logic [2:0] SEL_IB3  = 3'd1;  // ibox_result3
  localparam logic [2:0] SEL_IB4  = 3'd2;  // ibox_result4
  localparam logic [2:0] SEL_MEM  = 3'd3;  // mem_out
  localparam logic [2:0] SEL_MREG = 3'd4;  // m_reg_out

  // One in-flight instruction as tracked in stages 3-5.
  typedef struct packed {
    logic                 valid;
    logic [NREG_BITS-1:0] dest;
    logic                 we;
    logic                 load;
  } pipe_entry_t;

  // Empty pipeline slot; dest parked on the zero register so it never matches.
  localparam pipe_entry_t BUBBLE = '{valid: 1'b0, dest: ZERO_REG, we: 1'b0, load: 1'b0};

  // An entry produces a value for src when it is live, writes, and targets src.
  function automatic logic entry_hits(input pipe_entry_t e, input logic [NREG_BITS-1:0] src);
    return e.valid & e.we & (e.dest == src);
  endfunction

endpackage

// File: rtl/irf_bypass_match.sv
// Per-operand priority match against stages 3-5: picks the youngest producer
// and flags a load-use hazard when that producer is a load still in stage 3.
module irf_bypass_match
  import irf_bypass_ctrl_pkg::*;
(
  input  logic [NREG_BITS-1:0] src,
  input  logic                 use_src,
  input  pipe_entry_t          s3,
  input  pipe_entry_t          s4,
  input  pipe_entry_t          s5,
  output logic [2:0]           sel,
  output logic                 hazard
);

  // Youngest-first search; the zero register and unused operands read the RF.
  always_comb begin
    sel    = SEL_RF;
    hazard = 1'b0;
    if (use_src && (src != ZERO_REG)) begin
      if (entry_hits(s3, src)) begin
        if (s3.load) begin
          hazard = 1'b1;
        end else begin
          sel = SEL_IB3;
        end
      end else if (entry_hits(s4, src)) begin
        sel = s4.load ? SEL_MEM : SEL_IB4;
      end else if (entry_hits(s5, src)) begin
        sel = SEL_MREG;
      end
    end
  end

endmodule

// File: rtl/irf_bypass_ctrl.sv
// Bypass select, load-use stall and write-back control for the integer
// register file, tracking in-flight destinations through stages 3-5.
module irf_bypass_ctrl
  import irf_bypass_ctrl_pkg::*;
#(
  parameter int CNT_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic [NREG_BITS-1:0] src_a,
  input  logic [NREG_BITS-1:0] src_b,
  input  logic                 use_a,
  input  logic                 use_b,
  input  logic [NREG_BITS-1:0] dest,
  input  logic                 dest_we,
  input  logic                 is_load,
  input  logic                 flush,
  output logic [2:0]           mux3_sel,
  output logic [2:0]           mux4_sel,
  output logic                 stall,
  output logic [NREG_BITS-1:0] write_addr,
  output logic                 write_en,
  output logic [CNT_BITS-1:0]  stall_count
);

  pipe_entry_t s3_reg;
  pipe_entry_t s4_reg;
  pipe_entry_t s5_reg;
  pipe_entry_t s3_next;
  pipe_entry_t s4_next;

  logic [CNT_BITS-1:0] stall_count_reg;

  // Operand 0 is A (feeds mux3), operand 1 is B (feeds mux4).
  logic [NREG_BITS-1:0] op_src [2];
  logic                 op_use [2];
  logic [2:0]           op_sel [2];
  logic                 op_hazard [2];

  assign op_src[0] = src_a;
  assign op_src[1] = src_b;
  assign op_use[0] = use_a;
  assign op_use[1] = use_b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      irf_bypass_match u_match (
        .src     (op_src[gi]),
        .use_src (op_use[gi]),
        .s3      (s3_reg),
        .s4      (s4_reg),
        .s5      (s5_reg),
        .sel     (op_sel[gi]),
        .hazard  (op_hazard[gi])
      );
    end
  endgenerate

  assign mux3_sel = op_sel[0];
  assign mux4_sel = op_sel[1];

  // A redirect outranks a hazard: the waiting instruction is dead anyway.
  assign stall = issue_valid & ~flush & (op_hazard[0] | op_hazard[1]);

  // Next pipeline contents: stall/flush inject a bubble, flush also kills stage 3.
  always_comb begin
    s3_next = BUBBLE;
    s4_next = s3_reg;
    if (issue_valid && !stall && !flush) begin
      s3_next = '{valid: 1'b1, dest: dest, we: dest_we, load: is_load};
    end
    if (flush) begin
      s4_next = BUBBLE;
    end
  end

  // Pipeline advance and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s3_reg          <= BUBBLE;
      s4_reg          <= BUBBLE;
      s5_reg          <= BUBBLE;
      stall_count_reg <= '0;
    end else begin
      s3_reg <= s3_next;
      s4_reg <= s4_next;
      s5_reg <= s4_reg;
      if (stall && (stall_count_reg != '1)) begin
        stall_count_reg <= stall_count_reg + 1'b1;
      end
    end
  end

  assign stall_count = stall_count_reg;

  // Stage-5 write-back; the zero register is never written and idles the address.
  assign write_en   = s5_reg.valid & s5_reg.we & (s5_reg.dest != ZERO_REG);
  assign write_addr = write_en ? s5_reg.dest : ZERO_REG;

endmodule

// File: tb/tb_irf_bypass_ctrl.sv
// Directed test of irf_bypass_ctrl: reset, ALU forwarding chain, load-use
// stalls on both operands, youngest-producer priority, zero register, flush.
module tb_irf_bypass_ctrl;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  src_a;
  logic [4:0]  src_b;
  logic        use_a;
  logic        use_b;
  logic [4:0]  dest;
  logic        dest_we;
  logic        is_load;
  logic        flush;
  logic [2:0]  mux3_sel;
  logic [2:0]  mux4_sel;
  logic        stall;
  logic [4:0]  write_addr;
  logic        write_en;
  logic [31:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  irf_bypass_ctrl #(.CNT_BITS(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .src_a       (src_a),
    .src_b       (src_b),
    .use_a       (use_a),
    .use_b       (use_b),
    .dest        (dest),
    .dest_we     (dest_we),
    .is_load     (is_load),
    .flush       (flush),
    .mux3_sel    (mux3_sel),
    .mux4_sel    (mux4_sel),
    .stall       (stall),
    .write_addr  (write_addr),
    .write_en    (write_en),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic set_in(input bit iv, input int sa, input int sb, input bit ua, input bit ub,
                        input int d, input bit we, input bit ld, input bit fl);
    issue_valid = iv;
    src_a       = sa[4:0];
    src_b       = sb[4:0];
    use_a       = ua;
    use_b       = ub;
    dest        = d[4:0];
    dest_we     = we;
    is_load     = ld;
    flush       = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_mux3", {29'd0, mux3_sel}, 32'd0);
    check_eq("rst_mux4", {29'd0, mux4_sel}, 32'd0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_we", {31'd0, write_en}, 32'd0);
    check_eq("rst_waddr", {27'd0, write_addr}, 32'd31);
    check_eq("rst_cnt", stall_count, 32'd0);
    rst_n = 1'b1;
    tick();

    // ALU chain on r1
    set_in(1, 10, 11, 1, 1, 1, 1, 0, 0);
    check_eq("alu_issue_stall", {31'd0, stall}, 32'd0);
    tick();
    set_in(1, 1, 12, 1, 1, 20, 0, 0, 0);
    check_eq("alu_s3_mux3", {29'd0, mux3_sel}, 32'd1);
    check_eq("alu_s3_mux4_nomatch", {29'd0, mux4_sel}, 32'd0);
    tick();
    set_in(1, 13, 1, 0, 1, 21, 0, 0, 0);
    check_eq("alu_s4_mux4", {29'd0, mux4_sel}, 32'd2);
    check_eq("alu_s4_mux3_unused", {29'd0, mux3_sel}, 32'd0);
    tick();
    set_in(1, 14, 1, 0, 1, 22, 0, 0, 0);
    check_eq("alu_s5_mux4", {29'd0, mux4_sel}, 32'd4);
    check_eq("alu_s5_we", {31'd0, write_en}, 32'd1);
    check_eq("alu_s5_waddr", {27'd0, write_addr}, 32'd1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("alu_nowrite_reader", {31'd0, write_en}, 32'd0);
    idle(3);

    // Load-use on operand A (LD r2)
    set_in(1, 0, 0, 0, 0, 2, 1, 1, 0);
    tick();
    set_in(1, 2, 0, 1, 0, 23, 0, 0, 0);
    check_eq("ldA_stall", {31'd0, stall}, 32'd1);
    check_eq("ldA_mux3_dc", {29'd0, mux3_sel}, 32'd0);
    check_eq("ldA_cnt_before", stall_count, 32'd0);
    tick();
    set_in(1, 2, 0, 1, 0, 23, 0, 0, 0);
    check_eq("ldA_stall_released", {31'd0, stall}, 32'd0);
    check_eq("ldA_mux3_mem", {29'd0, mux3_sel}, 32'd3);
    check_eq("ldA_cnt_after", stall_count, 32'd1);
    tick();
    idle(3);

    // Load-use on operand B (LD r5), then S5 load forwards via m_reg_out
    set_in(1, 0, 0, 0, 0, 5, 1, 1, 0);
    tick();
    set_in(1, 5, 5, 0, 1, 24, 0, 0, 0);
    check_eq("ldB_stall", {31'd0, stall}, 32'd1);
    tick();
    set_in(1, 5, 5, 0, 1, 24, 0, 0, 0);
    check_eq("ldB_mux4_mem", {29'd0, mux4_sel}, 32'd3);
    check_eq("ldB_cnt", stall_count, 32'd2);
    tick();
    set_in(1, 0, 5, 0, 1, 25, 0, 0, 0);
    check_eq("ldB_s5_mux4", {29'd0, mux4_sel}, 32'd4);
    check_eq("ldB_s5_we", {31'd0, write_en}, 32'd1);
    check_eq("ldB_s5_waddr", {27'd0, write_addr}, 32'd5);
    tick();
    idle(3);

    // Priority: ADD r3 then SUB r3, reader takes the younger one
    set_in(1, 0, 0, 0, 0, 3, 1, 0, 0);
    tick();
    set_in(1, 0, 0, 0, 0, 3, 1, 0, 0);
    tick();
    set_in(1, 3, 3, 1, 0, 26, 0, 0, 0);
    check_eq("prio_mux3_youngest", {29'd0, mux3_sel}, 32'd1);
    check_eq("prio_mux4_unused", {29'd0, mux4_sel}, 32'd0);
    tick();
    idle(3);

    // Zero register is tracked but never forwarded or written
    set_in(1, 0, 0, 0, 0, 31, 1, 0, 0);
    tick();
    set_in(1, 31, 31, 1, 1, 27, 0, 0, 0);
    check_eq("zero_mux3", {29'd0, mux3_sel}, 32'd0);
    check_eq("zero_mux4", {29'd0, mux4_sel}, 32'd0);
    tick();
    idle(1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("zero_s5_we", {31'd0, write_en}, 32'd0);
    check_eq("zero_s5_waddr", {27'd0, write_addr}, 32'd31);
    idle(3);

    // Flush kills a load in S3 and its waiting dependent
    set_in(1, 0, 0, 0, 0, 4, 1, 1, 0);
    tick();
    set_in(1, 4, 0, 1, 0, 28, 0, 0, 1);
    check_eq("flush_stall", {31'd0, stall}, 32'd0);
    tick();
    set_in(0, 4, 0, 1, 0, 0, 0, 0, 0);
    check_eq("flush_killed_mux3", {29'd0, mux3_sel}, 32'd0);
    check_eq("flush_we1", {31'd0, write_en}, 32'd0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("flush_we2", {31'd0, write_en}, 32'd0);
    check_eq("flush_waddr2", {27'd0, write_addr}, 32'd31);
    check_eq("flush_cnt", stall_count, 32'd2);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irf_bypass_ctrl.md
Name: irf_bypass_ctrl

Overview:
- Control-side partner of the integer register file: generates the operand-bypass selects that the register file's A/B operand muxes consume, plus the write-back address and enable the register file's write port receives.
- Tracks destination registers of in-flight instructions through stages 3–5.
- Detects load-use hazards and stalls issue.
- Sits beside the integer register file at the decode/issue boundary (stage 2).

Parameters:
- NREG_BITS, 5, register address width.
- ZERO_REG, 31, hard-wired zero register; never forwarded, never written.
- CNT_BITS, 32, stall performance counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- issue_valid  in  1  stage-2 instruction present and wants to issue.
- src_a  in  5  stage-2 read address A.
- src_b  in  5  stage-2 read address B.
- use_a  in  1  instruction reads A.
- use_b  in  1  instruction reads B.
- dest  in  5  destination register of the stage-2 instruction.
- dest_we  in  1  instruction writes dest.
- is_load  in  1  instruction is a load; result is available at mem_out in stage 4.
- flush  in  1  kill the stage-2 and stage-3 instructions (branch redirect).
- mux3_sel  out  3  A-operand bypass select.
- mux4_sel  out  3  B-operand bypass select.
- stall  out  1  hold stage 2 and insert a bubble into stage 3.
- write_addr  out  5  register file write address (stage-5 destination).
- write_en  out  1  register file write enable.
- stall_count  out  CNT_BITS  saturating count of stall cycles.

Behaviour:
- State: three pipeline entries S3, S4, S5, each holding {valid, dest, we, load}.
- Every posedge: S5<=S4 and S4<=S3.
  - S3 <= stage-2 instruction, with valid = issue_valid & ~stall & ~flush.
  - On stall or flush, S3 is loaded as a bubble (valid=0).
- A bubble also clears the "flush kills S3" case: flush sets S3.valid=0 on the entry that moves to S4 in that cycle.
  - Equivalently: with flush asserted, S4 <= bubble; S5 is unaffected.
- Reset (rst_n=0 at posedge): all valid=0, stall_count=0.
  - Outputs after reset: mux3_sel=0, mux4_sel=0, stall=0, write_en=0, write_addr=31.
- Select encoding (combinational from src, use, S3–S5):
  - 0 = register file, 1 = ibox_result3, 2 = ibox_result4, 3 = mem_out, 4 = m_reg_out.
  - Codes 5–7 are never driven.
- Matching and priority per operand X:
  - No match if use_X=0 or src_X==ZERO_REG; sel=0.
  - Otherwise the youngest matching entry wins, checked in order S3, S4, S5. An entry matches when valid & we & dest==src_X.
  - S3 match: sel=1 if ~load; if load, the hazard is raised and sel is don't-care (driven 0).
  - S4 match: sel=3 if load, else 2.
  - S5 match: sel=4.
- stall = issue_valid & ~flush & (hazard_A | hazard_B). Combinational, so the hazard lasts exactly one cycle: a load stalls a dependent by one cycle, after which the load is in S4 and the operand takes mem_out (sel=3).
- Write-back:
  - write_en = S5.valid & S5.we & (S5.dest != ZERO_REG).
  - write_addr = S5.dest when write_en, else 31.
  - The register file writes on negedge, so a stage-2 read of the stage-5 register also resolves through the S5 match (sel=4). Both paths give the same value.
- stall_count increments on each posedge with stall=1 and saturates at all-ones.
- Simultaneous flush and hazard: flush wins; stall=0.
- dest==31 with dest_we=1: tracked in the entry, but never matches a source (zero-reg rule) and never writes.

Decomposition:
- Shared package holds:
  - select-code constants (SEL_RF=0, SEL_IB3=1, SEL_IB4=2, SEL_MEM=3, SEL_MREG=4);
  - ZERO_REG;
  - the pipeline-entry struct {valid, dest, we, load}.
- One sub-module, irf_bypass_match: combinational per-operand priority match returning {sel, hazard}. Instantiated twice (A and B).

Test Plan:
- Reset: hold rst_n=0 for 2 cycles → all sels=0, stall=0, write_en=0, write_addr=31, stall_count=0.
- ALU chain: issue ADD r1, then next cycle issue with src_a=r1 → mux3_sel=1. One cycle later with src_b=r1 → mux4_sel=2. Two cycles later → mux4_sel=4, write_en=1, write_addr=1.
- Load-use: issue LD r2, then next cycle issue with src_a=r2 → stall=1 for 1 cycle, stall_count=1. Next cycle → stall=0, mux3_sel=3.
- Priority: ADD r3 then SUB r3 back-to-back, then a reader with src_a=r3 → mux3_sel=1 (youngest), not 2.
- Zero register: ADD r31 followed by a reader with src_a=r31 → mux3_sel=0; when the ADD reaches stage 5, write_en=0.
- Flush: LD r4 in S3 and a dependent in stage 2 with flush=1 → stall=0. The load never reaches write-back (write_en stays 0 for r4).
